video_line_packer: RTL and testbench
====================================

# video_line_packer

Receive end of the RGB565 video interface. Captures each active line of `video_de`/`video_data` into a ping-pong line buffer and emits it as one byte-stream packet, with a 4-byte header, toward the UDP/GMII transmit path. Lines of wrong length or arriving while both buffers are busy are dropped and counted. Shares `sys_clk` with the video source.

## Interface
Parameters:
- `H_ACTIVE`, 1920: pixels per valid line.
- `V_ACTIVE`, 1080: valid lines per frame.
- `SYNC_BYTE`, 8'hA5: first header byte.

Ports:
- `sys_clk` in 1: single clock for video input and byte output.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `video_rst` in 1: frame sync from the source. Active-high, may stay high for many cycles; only its rising edge is used.
- `video_de` in 1: pixel valid.
- `video_data` in 16: RGB565 pixel, R[15:11] G[10:5] B[4:0].
- `tx_data` out 8: packet byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: downstream accepts the byte.
- `tx_last` out 1: final byte of the packet.
- `frame_id` out 8: frame counter.
- `line_err` out 1: one-cycle pulse when a line is dropped for length or line-index error.
- `ovf_cnt` out 16: saturating count of lines dropped because no bank was free.

## Operation
- **Frame sync**
  - A rising edge of `video_rst` (registered, compared with its previous value) increments `frame_id` (8-bit wrap) and clears `line_id` to 0.
  - Any partially captured line is discarded, with no `line_err`.
- **Capture**
  - Each `video_de`=1 cycle writes `video_data` to the free bank at address `pix_cnt`, then `pix_cnt`++.
  - `pix_cnt` is 11-bit and saturates at `H_ACTIVE`; no write happens at or beyond `H_ACTIVE`.
- **End of line** (first cycle with `video_de`=0 after a `de`=1 run):
  - `pix_cnt`==`H_ACTIVE` and `line_id`<`V_ACTIVE`: the bank is marked full and tagged with {`frame_id`, `line_id`}.
  - Otherwise: pulse `line_err` and discard the line.
  - In all cases `line_id`++ (saturates at 2047) and `pix_cnt` is cleared.
- **Bank allocation**
  - Two banks (A, B) with full flags.
  - Capture starts in the non-full bank, A preferred.
  - A line that starts while both banks are full is dropped whole and `ovf_cnt`++; `line_id` still advances.
- **Transmit FSM**: IDLE → HDR → PIX → IDLE.
  - IDLE: the oldest full bank is selected; the FSM enters HDR with byte index 0.
  - HDR: sends `SYNC_BYTE`, `frame_id`, {5'b0, `line_id[10:8]`}, `line_id[7:0]`.
  - PIX: sends 2×`H_ACTIVE` bytes, pixel order 0..H-1, MSB byte first.
  - The last PIX byte has `tx_last`=1. On its handshake the bank's full flag clears and the FSM returns to IDLE.
- **Handshake**
  - A byte transfers on `tx_valid` && `tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_last` hold stable.
  - `tx_valid` never drops mid-packet.
- **Simultaneous events**
  - TX releasing a bank in the same cycle a new line needs one: the release takes effect first, so the line is captured and there is no overflow.
  - Capture completing and TX selection in the same cycle: TX picks the bank on the following cycle.
- **`sys_rst`**
  - Aborts any packet, clears both full flags, and returns the FSM to IDLE.
  - All outputs go to 0: `tx_data`, `tx_valid`, `tx_last`, `frame_id`, `line_err`, `ovf_cnt`. The internal counters `line_id` and `pix_cnt` are also cleared.

## Timing
- `video_de` falls, first low sampled at cycle N: full flag set at N+1, `tx_valid`=1 with `SYNC_BYTE` at N+2 (TX idle case).
- With `tx_ready` held high, a packet is exactly 4+2×`H_ACTIVE` consecutive cycles (3844 at 1920) with no bubbles. Bank read latency of 1 cycle is hidden by prefetch.
- Source line period is 2048 cycles, which is less than 3844. Throughput therefore relies on the double buffer plus downstream throttling; sustained full rate overflows by design and shows as `ovf_cnt` growth.
- `frame_id` updates on the cycle after the `video_rst` rising edge is detected.
- `line_err` is a 1-cycle pulse at N+1.

## Structure
- Package `video_pkt_pkg`:
  - `SYNC_BYTE` default, `HDR_LEN`=4.
  - TX state enum `{IDLE, HDR, PIX}`.
  - Header field widths.
- Sub-module `line_bank_ram`: simple dual-port, 16 bits × `H_ACTIVE`, 1-cycle registered read. Instantiated twice (banks A and B).

## Test plan
- **Nominal line:** one 1920-pixel line of color bars (first 240 px 16'hFFFF, next 240 px 16'hFFE0), `tx_ready`=1.
  - Expect bytes A5, 00, 00, 00, then FF FF … FF E0 …
  - `tx_last` on byte 3843.
  - `tx_valid` first high at N+2.
- **Back-pressure:** toggle `tx_ready` pseudo-randomly.
  - `tx_data` is stable during every stall.
  - Packet contents are identical to the nominal case.
- **Short line:** a 1919-pixel line produces a `line_err` pulse and no packet. The next valid line carries `line_id`=1.
- **Overflow:** `tx_ready`=0 across three full lines.
  - Lines 0 and 1 are buffered; line 2 is dropped with `ovf_cnt`=1.
  - After releasing `tx_ready`, packets appear for lines 0 and 1 only.
- **Frame sync:** a `video_rst` high pulse of 2048 cycles mid-line.
  - `frame_id` increments by exactly 1.
  - The partial line is discarded.
  - The next packet header carries `line_id`=0.
- **Async reset:** assert `sys_rst` mid-packet.
  - Outputs go to 0 immediately.
  - After release, the first packet starts with A5, 00, 00, 00.

Source files
------------

// File: rtl/video_pkt_pkg.sv
// video_pkt_pkg: shared constants, TX state and header helper for video_line_packer
package video_pkt_pkg;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int HDR_LEN = 4;
  localparam int FRAME_W = 8;
  localparam int LINE_W = 11;
  typedef enum logic [1:0] {IDLE, HDR, PIX} tx_state_t;
  function automatic logic [7:0] hdr_byte(input logic [1:0] i, input logic [7:0] sync,
                                          input logic [FRAME_W-1:0] frame, input logic [LINE_W-1:0] line);
    return i == 2'd0 ? sync : i == 2'd1 ? frame : i == 2'd2 ? {5'b0, line[10:8]} : line[7:0];
  endfunction
endpackage

// File: rtl/line_bank_ram.sv
// line_bank_ram: simple dual-port 16-bit line buffer with 1-cycle registered read
module line_bank_ram
  import video_pkt_pkg::*;
#(
  parameter int DEPTH = 1920
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LINE_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [LINE_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);
  logic [15:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/video_line_packer.sv
// video_line_packer: captures RGB565 lines into ping-pong banks and streams each as a headed byte packet
module video_line_packer
  import video_pkt_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        video_rst,
  input  logic        video_de,
  input  logic [15:0] video_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  frame_id,
  output logic        line_err,
  output logic [15:0] ovf_cnt
);
  localparam logic [LINE_W-1:0] H_CNT = 11'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_CNT = 11'(V_ACTIVE);
  localparam logic [LINE_W-1:0] LAST_PIX = 11'(H_ACTIVE - 1);
  localparam logic [11:0] LAST_BYTE = 12'(2 * H_ACTIVE - 1);
  localparam logic [11:0] HDR_LAST = 12'(HDR_LEN - 1);

  logic r_vrst, r_de_d, r_kill, r_drop, r_cap_bank, r_first, r_tx_bank;
  logic [LINE_W-1:0] r_pix_cnt, r_line_id, r_raddr;
  logic [1:0] r_full;
  logic [1:0][FRAME_W-1:0] r_tag_frame;
  logic [1:0][LINE_W-1:0] r_tag_line;
  logic [11:0] r_idx;
  logic [7:0] r_lsb;
  tx_state_t r_state, w_state_nxt;
  logic w_sync, w_sol, w_eol, w_xfer, w_rel, w_both, w_bank, w_drop, w_we, w_end, w_ok, w_good, w_rd_bank;
  logic [1:0] w_full_eff, w_set;
  logic [15:0] w_q_a, w_q_b, w_q;

  assign w_sync = video_rst & ~r_vrst;
  assign w_sol = video_de & ~r_de_d;
  assign w_eol = ~video_de & r_de_d;
  assign w_xfer = tx_valid & tx_ready;
  assign w_rel = (r_state == PIX) & w_xfer & tx_last;
  // a bank released this cycle is already free for a line starting now
  assign w_full_eff = r_full & ~(w_rel ? (r_tx_bank ? 2'b10 : 2'b01) : 2'b00);
  assign w_both = &w_full_eff;
  assign w_bank = w_sol ? w_full_eff[0] : r_cap_bank;
  assign w_drop = w_sol ? w_both : r_drop;
  assign w_we = video_de & ~w_drop & (r_pix_cnt < H_CNT);
  assign w_end = w_eol & ~r_kill & ~r_drop;
  assign w_ok = (r_pix_cnt == H_CNT) & (r_line_id < V_CNT);
  assign w_good = w_end & w_ok;
  assign w_set = w_good ? (r_cap_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_rd_bank = (&r_full) ? r_first : r_full[1];
  assign w_q = r_tx_bank ? w_q_b : w_q_a;

  line_bank_ram #(.DEPTH(H_ACTIVE)) u_bank_a (
    .i_clk(sys_clk), .i_we(w_we & ~w_bank), .i_waddr(r_pix_cnt), .i_wdata(video_data),
    .i_raddr(r_raddr), .o_rdata(w_q_a)
  );
  line_bank_ram #(.DEPTH(H_ACTIVE)) u_bank_b (
    .i_clk(sys_clk), .i_we(w_we & w_bank), .i_waddr(r_pix_cnt), .i_wdata(video_data),
    .i_raddr(r_raddr), .o_rdata(w_q_b)
  );

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_vrst <= 1'b0;
      r_de_d <= 1'b0;
      r_kill <= 1'b0;
      r_drop <= 1'b0;
      r_cap_bank <= 1'b0;
      r_pix_cnt <= '0;
      r_line_id <= '0;
      r_full <= '0;
      r_first <= 1'b0;
      r_tag_frame <= '0;
      r_tag_line <= '0;
      frame_id <= '0;
      line_err <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      r_vrst <= video_rst;
      r_de_d <= video_de;
      r_kill <= w_sync | (r_kill & ~w_sol);
      if (w_sync) frame_id <= frame_id + 8'd1;
      if (w_sol) begin
        r_cap_bank <= w_full_eff[0];
        r_drop <= w_both;
      end
      if (w_sol & w_both & ~&ovf_cnt) ovf_cnt <= ovf_cnt + 16'd1;
      r_pix_cnt <= w_eol ? '0 : (video_de & (r_pix_cnt < H_CNT)) ? r_pix_cnt + 11'd1 : r_pix_cnt;
      r_line_id <= w_sync ? '0 : (w_eol & ~r_kill & ~&r_line_id) ? r_line_id + 11'd1 : r_line_id;
      line_err <= w_end & ~w_ok;
      r_full <= w_full_eff | w_set;
      if (w_good) begin
        r_tag_frame[r_cap_bank] <= frame_id;
        r_tag_line[r_cap_bank] <= r_line_id;
        r_first <= w_full_eff[!r_cap_bank] ? !r_cap_bank : r_cap_bank;
      end
    end

  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = (r_state == IDLE && |r_full) ? HDR :
                  (r_state == HDR && w_xfer && r_idx == HDR_LAST) ? PIX :
                  w_rel ? IDLE : r_state;
  end

  // pixel p+1 is fetched while both bytes of pixel p are on the wire
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      tx_data <= '0;
      tx_valid <= 1'b0;
      tx_last <= 1'b0;
      r_tx_bank <= 1'b0;
      r_idx <= '0;
      r_raddr <= '0;
      r_lsb <= '0;
    end else if (r_state == IDLE) begin
      if (|r_full) begin
        r_tx_bank <= w_rd_bank;
        tx_valid <= 1'b1;
        tx_data <= SYNC_BYTE;
        r_idx <= '0;
        r_raddr <= '0;
      end
    end else if (w_xfer) begin
      if (r_state == HDR && r_idx != HDR_LAST) begin
        tx_data <= hdr_byte(2'(r_idx[1:0] + 2'd1), SYNC_BYTE, r_tag_frame[r_tx_bank], r_tag_line[r_tx_bank]);
        r_idx <= r_idx + 12'd1;
      end else if (tx_last) begin
        tx_valid <= 1'b0;
        tx_last <= 1'b0;
      end else if (r_state == HDR || r_idx[0]) begin
        tx_data <= w_q[15:8];
        r_lsb <= w_q[7:0];
        r_raddr <= (r_raddr == LAST_PIX) ? r_raddr : r_raddr + 11'd1;
        r_idx <= (r_state == HDR) ? 12'd0 : r_idx + 12'd1;
      end else begin
        tx_data <= r_lsb;
        tx_last <= (r_idx + 12'd1 == LAST_BYTE);
        r_idx <= r_idx + 12'd1;
      end
    end
endmodule

// File: tb/tb_video_line_packer.sv
// tb_video_line_packer: directed and randomized checks of video_line_packer against a byte-queue model
module tb_video_line_packer;
  localparam int H = 32;
  localparam int V = 4;
  localparam logic [7:0] SB = 8'hA5;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic video_rst = 1'b0;
  logic video_de = 1'b0;
  logic tx_ready = 1'b1;
  logic [15:0] video_data = '0;
  logic [7:0] tx_data, frame_id;
  logic tx_valid, tx_last, line_err;
  logic [15:0] ovf_cnt;

  int n_vec = 0, n_err = 0;
  logic [8:0] exp_q[$];
  logic [15:0] pix[H+2];
  logic [15:0] bars[8];
  logic [7:0] m_frame = '0;
  int m_line = 0, m_ovf = 0, m_lerr = 0, n_lerr = 0, n_rx = 0, n_exp = 0, bp_mode = 0;
  int bad = 0, stall_bad = 0, cur_len = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  logic [8:0] e;

  video_line_packer #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_BYTE(SB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .video_rst(video_rst), .video_de(video_de),
    .video_data(video_data), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .frame_id(frame_id), .line_err(line_err), .ovf_cnt(ovf_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic model_line(input int len);
    int outst = 0;
    logic [10:0] l;
    l = 11'(m_line);
    foreach (exp_q[i]) if (exp_q[i][8]) outst++;
    if (outst >= 2) m_ovf++;
    else if (len == H && m_line < V) begin
      exp_q.push_back({1'b0, SB});
      exp_q.push_back({1'b0, m_frame});
      exp_q.push_back({1'b0, 5'b0, l[10:8]});
      exp_q.push_back({1'b0, l[7:0]});
      for (int i = 0; i < H; i++) begin
        exp_q.push_back({1'b0, pix[i][15:8]});
        exp_q.push_back({i == H - 1, pix[i][7:0]});
      end
      n_exp++;
    end else m_lerr++;
    if (m_line < 2047) m_line++;
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < H + 2; i++) pix[i] = (kind == 0) ? bars[(i / (H / 8)) % 8] : 16'($urandom);
  endtask

  task automatic drive_px(input int a, input int b);
    for (int i = a; i < b; i++) begin
      video_de = 1'b1;
      video_data = pix[i];
      tick(1);
    end
  endtask

  task automatic send_line(input int len);
    model_line(len);
    drive_px(0, len);
    video_de = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    tick(4);
    while ((exp_q.size() != 0 || tx_valid) && n < 3000) begin
      tick(1);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic sync_pulse(input int len);
    video_rst = 1'b1;
    m_frame++;
    m_line = 0;
    tick(len);
    video_rst = 1'b0;
    tick(2);
  endtask

  initial forever begin
    @(posedge sys_clk);
    #1;
    tx_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  initial forever begin
    @(negedge sys_clk);
    if (sys_rst) begin
      bad = 0;
      stall_bad = 0;
      cur_len = 0;
      prev_stall = 1'b0;
    end else begin
      if (line_err) n_lerr++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last)) stall_bad++;
      if (cur_len > 0 && !tx_valid) stall_bad++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_last = tx_last;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) bad++;
        else begin
          e = exp_q.pop_front();
          if ({tx_last, tx_data} !== e) bad++;
        end
        cur_len++;
        if (tx_last) begin
          chk("pkt_bytes", bad, 0);
          chk("pkt_stall", stall_bad, 0);
          n_rx++;
          bad = 0;
          stall_bad = 0;
          cur_len = 0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, len;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    tick(3);
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_last", tx_last, 0);
    chk("rst_frame", frame_id, 0);
    chk("rst_lerr", line_err, 0);
    chk("rst_ovf", ovf_cnt, 0);
    sys_rst = 1'b0;
    tick(3);

    fill(0);
    send_line(H);
    tick(1);
    chk("nom_n1_valid", tx_valid, 0);
    tick(1);
    chk("nom_n2_valid", tx_valid, 1);
    chk("nom_n2_data", tx_data, SB);
    c = 0;
    while (tx_valid && c < 1000) begin
      tick(1);
      c++;
    end
    chk("nom_cycles", c, 4 + 2 * H);
    drain("nom_drain");

    fill(1);
    drive_px(0, 10);
    video_rst = 1'b1;
    m_frame++;
    m_line = 0;
    drive_px(10, H);
    video_de = 1'b0;
    tick(2048 - (H - 10));
    video_rst = 1'b0;
    tick(5);
    chk("fsync_frame", frame_id, m_frame);
    chk("fsync_nopkt", tx_valid, 0);
    chk("fsync_lerr", n_lerr, m_lerr);

    fill(1);
    send_line(H - 1);
    tick(1);
    chk("short_err_n1", line_err, 1);
    tick(1);
    chk("short_err_n2", line_err, 0);
    tick(10);
    chk("short_nopkt", tx_valid, 0);
    fill(1);
    send_line(H);
    drain("short_next");

    bp_mode = 1;
    repeat (2) begin
      fill(1);
      send_line(H);
      drain("bp_drain");
    end
    bp_mode = 0;

    fill(1);
    send_line(H);
    tick(1);
    chk("vmax_err", line_err, 1);
    tick(10);
    chk("vmax_nopkt", tx_valid, 0);

    sync_pulse(3);
    bp_mode = 2;
    tick(2);
    repeat (3) begin
      fill(1);
      send_line(H);
      tick(4);
    end
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("ovf_stall_valid", tx_valid, 1);
    bp_mode = 0;
    drain("ovf_drain");
    chk("ovf_pkts", n_rx, n_exp);

    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 3) == 0) sync_pulse($urandom_range(1, 4));
      bp_mode = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: len = H - 1;
        1: len = $urandom_range(1, H - 2);
        default: len = H;
      endcase
      fill(1);
      send_line(len);
      tick($urandom_range(1, 8));
      drain("rnd_drain");
      chk("rnd_frame", frame_id, m_frame);
      chk("rnd_ovf", ovf_cnt, m_ovf);
    end
    bp_mode = 0;

    fill(1);
    send_line(H);
    tick(10);
    chk("arst_pre_valid", tx_valid, 1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_last", tx_last, 0);
    chk("arst_frame", frame_id, 0);
    chk("arst_ovf", ovf_cnt, 0);
    exp_q.delete();
    n_exp = n_rx;
    m_frame = '0;
    m_line = 0;
    m_ovf = 0;
    tick(3);
    sys_rst = 1'b0;
    tick(2);
    fill(0);
    send_line(H);
    drain("arst_after");

    tick(5);
    chk("final_expq", exp_q.size(), 0);
    chk("final_pkts", n_rx, n_exp);
    chk("final_lerr", n_lerr, m_lerr);
    chk("final_ovf", ovf_cnt, m_ovf);
    chk("final_tail", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
